// File: rtl/rs_pkg.sv
// Shared types and constants for the parametrised reservation station.
// RS_IMM_MUX_EN (optional) selects the immediate-as-source-2 path at allocation.
package rs_pkg;

  localparam int RS_XLEN  = 64;
  localparam int RS_TAG_W = 6;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef struct packed {
    logic                valid;
    logic [6:0]          opcode;
    logic [2:0]          funct3;
    logic [11:0]         imm;
    logic [RS_TAG_W-1:0] tag;
    logic [RS_TAG_W-1:0] rd;
    logic [RS_TAG_W-1:0] src1_tag;
    logic [RS_XLEN-1:0]  src1_val;
    logic                src1_rdy;
    logic [RS_TAG_W-1:0] src2_tag;
    logic [RS_XLEN-1:0]  src2_val;
    logic                src2_rdy;
  } rs_entry_t;

  function automatic logic is_imm_op(input logic [6:0] opc);
    return (opc == OPC_OP_IMM) || (opc == OPC_LOAD) || (opc == OPC_JALR);
  endfunction

  function automatic logic [RS_XLEN-1:0] sext_imm(input logic [11:0] imm);
    return {{(RS_XLEN-12){imm[11]}}, imm};
  endfunction

endpackage

// File: rtl/rs_param_if.sv
// Bundle between rename/RF read, the result broadcast buses, the RS and its execution unit.
// alloc_* and issue_* are valid/ready pairs: a transfer happens on a posedge where valid && ready; payload is meaningful only while valid.
interface rs_param_if #(
  parameter int NUM_WB = 4,
  parameter int XLEN   = 64,
  parameter int TAG_W  = 6,
  parameter int CNT_W  = 4
);
  logic                    alloc_valid;
  logic                    alloc_ready;
  logic [6:0]              alloc_opcode;
  logic [2:0]              alloc_funct3;
  logic [11:0]             alloc_imm;
  logic [TAG_W-1:0]        alloc_tag;
  logic [TAG_W-1:0]        alloc_rd;
  logic [TAG_W-1:0]        alloc_src1_tag;
  logic [TAG_W-1:0]        alloc_src2_tag;
  logic [XLEN-1:0]         alloc_src1_val;
  logic [XLEN-1:0]         alloc_src2_val;
  logic                    alloc_src1_rdy;
  logic                    alloc_src2_rdy;

  logic [NUM_WB-1:0]       wb_valid;
  logic [NUM_WB*TAG_W-1:0] wb_tag;
  logic [NUM_WB*XLEN-1:0]  wb_data;

  logic                    issue_valid;
  logic                    issue_ready;
  logic [6:0]              issue_opcode;
  logic [2:0]              issue_funct3;
  logic [11:0]             issue_imm;
  logic [TAG_W-1:0]        issue_tag;
  logic [TAG_W-1:0]        issue_rd;
  logic [XLEN-1:0]         issue_src1;
  logic [XLEN-1:0]         issue_src2;

  logic [CNT_W-1:0]        count;

  modport slave (
    input  alloc_valid, alloc_opcode, alloc_funct3, alloc_imm, alloc_tag, alloc_rd,
           alloc_src1_tag, alloc_src2_tag, alloc_src1_val, alloc_src2_val,
           alloc_src1_rdy, alloc_src2_rdy, wb_valid, wb_tag, wb_data, issue_ready,
    output alloc_ready, issue_valid, issue_opcode, issue_funct3, issue_imm,
           issue_tag, issue_rd, issue_src1, issue_src2, count
  );

  modport master (
    output alloc_valid, alloc_opcode, alloc_funct3, alloc_imm, alloc_tag, alloc_rd,
           alloc_src1_tag, alloc_src2_tag, alloc_src1_val, alloc_src2_val,
           alloc_src1_rdy, alloc_src2_rdy, wb_valid, wb_tag, wb_data, issue_ready,
    input  alloc_ready, issue_valid, issue_opcode, issue_funct3, issue_imm,
           issue_tag, issue_rd, issue_src1, issue_src2, count
  );
endinterface

// File: rtl/rs_age_matrix.sv
// Allocation-order tracker: older[i][j] set means entry i was allocated before entry j.
// Produces a one-hot of the oldest entry among the ready vector.
module rs_age_matrix #(
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             res_n,
  input  logic             flush,
  input  logic [DEPTH-1:0] alloc_oh,
  input  logic [DEPTH-1:0] free_oh,
  input  logic [DEPTH-1:0] ready,
  output logic [DEPTH-1:0] oldest
);

  logic [DEPTH-1:0] older [DEPTH];
  logic [DEPTH-1:0] blocked;

  // A new entry is younger than everything: its column is set, its row cleared.
  always_ff @(posedge clk) begin
    if (!res_n || flush) begin
      for (int i = 0; i < DEPTH; i++) older[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        for (int j = 0; j < DEPTH; j++) begin
          if (i != j) begin
            if (alloc_oh[j])
              older[i][j] <= 1'b1;
            else if (alloc_oh[i] || free_oh[i] || free_oh[j])
              older[i][j] <= 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    blocked = '0;
    oldest  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        if ((i != j) && ready[j] && older[j][i]) blocked[i] = 1'b1;
      end
      oldest[i] = ready[i] && !blocked[i];
    end
  end

endmodule

// File: rtl/rs_param.sv
// Parametrised reservation station: holds renamed instructions until both operands arrive, issues oldest-ready.
// Build option RS_IMM_MUX_EN: OP-IMM/LOAD/JALR take source 2 from the sign-extended immediate at allocation.
module rs_param
  import rs_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int NUM_WB = 4,
  parameter int XLEN   = RS_XLEN,
  parameter int TAG_W  = RS_TAG_W
) (
  input  logic          clk,
  input  logic          res_n,
  input  logic          flush,
  rs_param_if.slave     bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  rs_entry_t        ent [DEPTH];
  logic [CNT_W-1:0] count_q;
  logic [DEPTH-1:0] lock_sel;

  logic [DEPTH-1:0] free_slot, alloc_oh, free_oh, rdy_vec, oldest, sel;
  logic             slot_found, alloc_fire, issue_valid, issue_fire;
  logic [XLEN:0]    wk1 [DEPTH];
  logic [XLEN:0]    wk2 [DEPTH];
  logic [XLEN:0]    nb1, nb2;
  rs_entry_t        new_ent;

  // Lowest-indexed matching port wins: iterate downwards so it overwrites last.
  function automatic logic [XLEN:0] wb_pick(
    input logic [TAG_W-1:0]        t,
    input logic [NUM_WB-1:0]       v,
    input logic [NUM_WB*TAG_W-1:0] tags,
    input logic [NUM_WB*XLEN-1:0]  data
  );
    logic [XLEN:0] r;
    r = '0;
    for (int p = NUM_WB - 1; p >= 0; p--) begin
      if (v[p] && (tags[p*TAG_W +: TAG_W] == t)) r = {1'b1, data[p*XLEN +: XLEN]};
    end
    return r;
  endfunction

  assign bus.alloc_ready = (count_q != CNT_W'(DEPTH));
  assign bus.count       = count_q;
  assign alloc_fire      = bus.alloc_valid && bus.alloc_ready && !flush;

  always_comb begin
    free_slot  = '0;
    slot_found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!ent[i].valid && !slot_found) begin
        free_slot[i] = 1'b1;
        slot_found   = 1'b1;
      end
    end
    alloc_oh = alloc_fire ? free_slot : '0;
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      wk1[i] = wb_pick(ent[i].src1_tag, bus.wb_valid, bus.wb_tag, bus.wb_data);
      wk2[i] = wb_pick(ent[i].src2_tag, bus.wb_valid, bus.wb_tag, bus.wb_data);
      rdy_vec[i] = ent[i].valid && ent[i].src1_rdy && ent[i].src2_rdy;
    end
  end

  always_comb begin
    nb1 = wb_pick(bus.alloc_src1_tag, bus.wb_valid, bus.wb_tag, bus.wb_data);
    nb2 = wb_pick(bus.alloc_src2_tag, bus.wb_valid, bus.wb_tag, bus.wb_data);
    new_ent          = '0;
    new_ent.valid    = 1'b1;
    new_ent.opcode   = bus.alloc_opcode;
    new_ent.funct3   = bus.alloc_funct3;
    new_ent.imm      = bus.alloc_imm;
    new_ent.tag      = bus.alloc_tag;
    new_ent.rd       = bus.alloc_rd;
    new_ent.src1_tag = bus.alloc_src1_tag;
    new_ent.src1_rdy = bus.alloc_src1_rdy || nb1[XLEN];
    new_ent.src1_val = bus.alloc_src1_rdy ? bus.alloc_src1_val : nb1[XLEN-1:0];
    new_ent.src2_tag = bus.alloc_src2_tag;
    new_ent.src2_rdy = bus.alloc_src2_rdy || nb2[XLEN];
    new_ent.src2_val = bus.alloc_src2_rdy ? bus.alloc_src2_val : nb2[XLEN-1:0];
`ifdef RS_IMM_MUX_EN
    if (is_imm_op(bus.alloc_opcode)) begin
      new_ent.src2_tag = '0;
      new_ent.src2_rdy = 1'b1;
      new_ent.src2_val = sext_imm(bus.alloc_imm);
    end
`endif
  end

  rs_age_matrix #(.DEPTH(DEPTH)) u_age (
    .clk      (clk),
    .res_n    (res_n),
    .flush    (flush),
    .alloc_oh (alloc_oh),
    .free_oh  (free_oh),
    .ready    (rdy_vec),
    .oldest   (oldest)
  );

  // A stalled presentation stays pinned so a newly woken older entry cannot swap the payload.
  assign sel         = (|lock_sel) ? lock_sel : oldest;
  assign issue_valid = (|sel) && !flush;
  assign issue_fire  = issue_valid && bus.issue_ready;
  assign free_oh     = issue_fire ? sel : '0;
  assign bus.issue_valid = issue_valid;

  always_comb begin
    bus.issue_opcode = '0;
    bus.issue_funct3 = '0;
    bus.issue_imm    = '0;
    bus.issue_tag    = '0;
    bus.issue_rd     = '0;
    bus.issue_src1   = '0;
    bus.issue_src2   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sel[i]) begin
        bus.issue_opcode = ent[i].opcode;
        bus.issue_funct3 = ent[i].funct3;
        bus.issue_imm    = ent[i].imm;
        bus.issue_tag    = ent[i].tag;
        bus.issue_rd     = ent[i].rd;
        bus.issue_src1   = ent[i].src1_val;
        bus.issue_src2   = ent[i].src2_val;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!res_n) begin
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
      count_q  <= '0;
      lock_sel <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) ent[i].valid <= 1'b0;
      count_q  <= '0;
      lock_sel <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (free_oh[i]) begin
          ent[i].valid <= 1'b0;
        end else if (alloc_oh[i]) begin
          ent[i] <= new_ent;
        end else if (ent[i].valid) begin
          if (!ent[i].src1_rdy && wk1[i][XLEN]) begin
            ent[i].src1_rdy <= 1'b1;
            ent[i].src1_val <= wk1[i][XLEN-1:0];
          end
          if (!ent[i].src2_rdy && wk2[i][XLEN]) begin
            ent[i].src2_rdy <= 1'b1;
            ent[i].src2_val <= wk2[i][XLEN-1:0];
          end
        end
      end
      case ({alloc_fire, issue_fire})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      lock_sel <= (issue_valid && !bus.issue_ready) ? sel : '0;
    end
  end

endmodule

// File: tb/tb_rs_param.sv
// Directed bench for rs_param (DEPTH=8, NUM_WB=4); inputs change on negedge, outputs sampled 1ns later.
module tb_rs_param;

  logic clk = 1'b0;
  logic res_n;
  logic flush;
  int   n_tests = 0;
  int   n_fail  = 0;

  rs_param_if #(.NUM_WB(4), .XLEN(64), .TAG_W(6), .CNT_W(4)) bus ();

  rs_param #(.DEPTH(8), .NUM_WB(4), .XLEN(64), .TAG_W(6)) dut (
    .clk   (clk),
    .res_n (res_n),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    bus.alloc_valid = 1'b0; bus.alloc_opcode = '0; bus.alloc_funct3 = '0; bus.alloc_imm = '0;
    bus.alloc_tag = '0; bus.alloc_rd = '0; bus.alloc_src1_tag = '0; bus.alloc_src2_tag = '0;
    bus.alloc_src1_val = '0; bus.alloc_src2_val = '0; bus.alloc_src1_rdy = 1'b0; bus.alloc_src2_rdy = 1'b0;
    bus.wb_valid = '0; bus.wb_tag = '0; bus.wb_data = '0;
    flush = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic drive_alloc(input logic [5:0] tag, input logic [6:0] opc, input logic [11:0] imm,
                             input logic [5:0] s1t, input logic s1r, input logic [63:0] s1v,
                             input logic [5:0] s2t, input logic s2r, input logic [63:0] s2v);
    bus.alloc_valid = 1'b1; bus.alloc_opcode = opc; bus.alloc_funct3 = 3'd1; bus.alloc_imm = imm;
    bus.alloc_tag = tag; bus.alloc_rd = tag + 6'd1;
    bus.alloc_src1_tag = s1t; bus.alloc_src1_rdy = s1r; bus.alloc_src1_val = s1v;
    bus.alloc_src2_tag = s2t; bus.alloc_src2_rdy = s2r; bus.alloc_src2_val = s2v;
  endtask

  task automatic drive_wb(input int p, input logic [5:0] t, input logic [63:0] d);
    bus.wb_valid[p] = 1'b1;
    bus.wb_tag[p*6 +: 6] = t;
    bus.wb_data[p*64 +: 64] = d;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    res_n = 1'b0; bus.issue_ready = 1'b0; clear_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk); res_n = 1'b1; #1;
    n_tests++; if (bus.alloc_ready !== 1'b1) begin n_fail++; $display("FAIL reset_alloc_ready: got %0b expected 1", bus.alloc_ready); end
    n_tests++; if (bus.issue_valid !== 1'b0) begin n_fail++; $display("FAIL reset_issue_valid: got %0b expected 0", bus.issue_valid); end
    n_tests++; if (bus.count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", bus.count); end
    n_tests++; if (bus.issue_src1 !== 64'd0) begin n_fail++; $display("FAIL reset_payload: got %0h expected 0", bus.issue_src1); end
  endtask

  task automatic test_basic();
    bus.issue_ready = 1'b1;
    drive_alloc(6'd3, 7'b0110011, 12'd0, 6'd0, 1'b1, 64'd5, 6'd0, 1'b1, 64'd7); #1;
    n_tests++; if (bus.issue_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early: got %0b expected 0", bus.issue_valid); end
    tick(); #1;
    n_tests++; if (bus.issue_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %0b expected 1", bus.issue_valid); end
    n_tests++; if (bus.issue_src1 !== 64'd5) begin n_fail++; $display("FAIL basic_src1: got %0h expected 5", bus.issue_src1); end
    n_tests++; if (bus.issue_src2 !== 64'd7) begin n_fail++; $display("FAIL basic_src2: got %0h expected 7", bus.issue_src2); end
    n_tests++; if (bus.issue_tag !== 6'd3) begin n_fail++; $display("FAIL basic_tag: got %0d expected 3", bus.issue_tag); end
    n_tests++; if (bus.issue_rd !== 6'd4) begin n_fail++; $display("FAIL basic_rd: got %0d expected 4", bus.issue_rd); end
    n_tests++; if (bus.count !== 4'd1) begin n_fail++; $display("FAIL basic_count1: got %0d expected 1", bus.count); end
    tick(); #1;
    n_tests++; if (bus.count !== 4'd0) begin n_fail++; $display("FAIL basic_count0: got %0d expected 0", bus.count); end
    n_tests++; if (bus.issue_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drained: got %0b expected 0", bus.issue_valid); end
  endtask

  task automatic test_alloc_bypass();
    bus.issue_ready = 1'b1;
    drive_alloc(6'd4, 7'b0110011, 12'd0, 6'd12, 1'b0, 64'd0, 6'd0, 1'b1, 64'd1);
    drive_wb(2, 6'd12, 64'hAB);
    tick(); #1;
    n_tests++; if (bus.issue_valid !== 1'b1) begin n_fail++; $display("FAIL bypass_valid: got %0b expected 1", bus.issue_valid); end
    n_tests++; if (bus.issue_src1 !== 64'hAB) begin n_fail++; $display("FAIL bypass_src1: got %0h expected ab", bus.issue_src1); end
    n_tests++; if (bus.issue_tag !== 6'd4) begin n_fail++; $display("FAIL bypass_tag: got %0d expected 4", bus.issue_tag); end
    tick(); #1;
    n_tests++; if (bus.count !== 4'd0) begin n_fail++; $display("FAIL bypass_count: got %0d expected 0", bus.count); end
  endtask

  task automatic test_wb_priority();
    bus.issue_ready = 1'b0;
    drive_alloc(6'd5, 7'b0110011, 12'd0, 6'd20, 1'b0, 64'd0, 6'd21, 1'b0, 64'd0);
    tick();
    drive_wb(3, 6'd20, 64'h33); drive_wb(1, 6'd20, 64'h11);
    drive_wb(2, 6'd21, 64'h22); drive_wb(0, 6'd21, 64'h21); #1;
    n_tests++; if (bus.issue_valid !== 1'b0) begin n_fail++; $display("FAIL wake_same_cycle: got %0b expected 0", bus.issue_valid); end
    tick(); #1;
    n_tests++; if (bus.issue_valid !== 1'b1) begin n_fail++; $display("FAIL wake_valid: got %0b expected 1", bus.issue_valid); end
    n_tests++; if (bus.issue_src1 !== 64'h11) begin n_fail++; $display("FAIL wake_prio_src1: got %0h expected 11", bus.issue_src1); end
    n_tests++; if (bus.issue_src2 !== 64'h21) begin n_fail++; $display("FAIL wake_prio_src2: got %0h expected 21", bus.issue_src2); end
    bus.issue_ready = 1'b1;
    tick(); #1;
    n_tests++; if (bus.count !== 4'd0) begin n_fail++; $display("FAIL wake_count: got %0d expected 0", bus.count); end
    bus.issue_ready = 1'b0;
  endtask

  task automatic test_age_hold();
    bus.issue_ready = 1'b0;
    drive_alloc(6'd1, 7'b0110011, 12'd0, 6'd9, 1'b0, 64'd0, 6'd0, 1'b1, 64'd2);
    tick();
    drive_alloc(6'd2, 7'b0110011, 12'd0, 6'd0, 1'b1, 64'hB1, 6'd0, 1'b1, 64'hB2); #1;
    n_tests++; if (bus.issue_valid !== 1'b0) begin n_fail++; $display("FAIL age_none_ready: got %0b expected 0", bus.issue_valid); end
    tick(); #1;
    n_tests++; if (bus.issue_tag !== 6'd2) begin n_fail++; $display("FAIL age_b_first: got %0d expected 2", bus.issue_tag); end
    drive_wb(0, 6'd9, 64'h99);
    tick(); #1;
    n_tests++; if (bus.issue_tag !== 6'd2) begin n_fail++; $display("FAIL age_hold_tag: got %0d expected 2", bus.issue_tag); end
    n_tests++; if (bus.issue_src1 !== 64'hB1) begin n_fail++; $display("FAIL age_hold_src1: got %0h expected b1", bus.issue_src1); end
    tick(); #1;
    n_tests++; if (bus.issue_tag !== 6'd2 || bus.issue_valid !== 1'b1) begin n_fail++; $display("FAIL age_hold_late: got tag %0d valid %0b expected tag 2 valid 1", bus.issue_tag, bus.issue_valid); end
    bus.issue_ready = 1'b1;
    tick(); #1;
    n_tests++; if (bus.issue_tag !== 6'd1) begin n_fail++; $display("FAIL age_a_next: got %0d expected 1", bus.issue_tag); end
    n_tests++; if (bus.issue_src1 !== 64'h99) begin n_fail++; $display("FAIL age_a_src1: got %0h expected 99", bus.issue_src1); end
    tick(); #1;
    n_tests++; if (bus.count !== 4'd0) begin n_fail++; $display("FAIL age_count: got %0d expected 0", bus.count); end
    bus.issue_ready = 1'b0;
  endtask

  task automatic test_full();
    bus.issue_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive_alloc(6'(i), 7'b0110011, 12'd0, 6'(32 + i), 1'b0, 64'd0, 6'd0, 1'b1, 64'd0);
      tick();
    end
    #1;
    n_tests++; if (bus.alloc_ready !== 1'b0) begin n_fail++; $display("FAIL full_alloc_ready: got %0b expected 0", bus.alloc_ready); end
    n_tests++; if (bus.count !== 4'd8) begin n_fail++; $display("FAIL full_count: got %0d expected 8", bus.count); end
    drive_alloc(6'd40, 7'b0110011, 12'd0, 6'd0, 1'b1, 64'd1, 6'd0, 1'b1, 64'd1);
    tick(); #1;
    n_tests++; if (bus.count !== 4'd8) begin n_fail++; $display("FAIL full_ignore_count: got %0d expected 8", bus.count); end
    n_tests++; if (bus.issue_valid !== 1'b0) begin n_fail++; $display("FAIL full_ignore_valid: got %0b expected 0", bus.issue_valid); end
    drive_wb(0, 6'd37, 64'h55);
    tick(); #1;
    n_tests++; if (bus.issue_tag !== 6'd5) begin n_fail++; $display("FAIL full_wake_tag: got %0d expected 5", bus.issue_tag); end
    n_tests++; if (bus.issue_src1 !== 64'h55) begin n_fail++; $display("FAIL full_wake_src1: got %0h expected 55", bus.issue_src1); end
    bus.issue_ready = 1'b1;
    n_tests++; if (bus.alloc_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready_same_cycle: got %0b expected 0", bus.alloc_ready); end
    tick(); #1;
    bus.issue_ready = 1'b0;
    n_tests++; if (bus.count !== 4'd7) begin n_fail++; $display("FAIL full_count7: got %0d expected 7", bus.count); end
    n_tests++; if (bus.alloc_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_after: got %0b expected 1", bus.alloc_ready); end
    flush = 1'b1;
    tick(); #1;
    n_tests++; if (bus.count !== 4'd0) begin n_fail++; $display("FAIL full_flush_count: got %0d expected 0", bus.count); end
  endtask

  task automatic test_flush();
    bus.issue_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_alloc(6'(10 + i), 7'b0110011, 12'd0, 6'(50 + i), 1'b0, 64'd0, 6'd0, 1'b1, 64'd0);
      tick();
    end
    drive_alloc(6'd14, 7'b0110011, 12'd0, 6'd0, 1'b1, 64'd3, 6'd0, 1'b1, 64'd4);
    tick(); #1;
    n_tests++; if (bus.issue_valid !== 1'b1 || bus.issue_tag !== 6'd14) begin n_fail++; $display("FAIL flush_pre: got valid %0b tag %0d expected valid 1 tag 14", bus.issue_valid, bus.issue_tag); end
    n_tests++; if (bus.count !== 4'd5) begin n_fail++; $display("FAIL flush_pre_count: got %0d expected 5", bus.count); end
    flush = 1'b1;
    drive_alloc(6'd15, 7'b0110011, 12'd0, 6'd0, 1'b1, 64'd1, 6'd0, 1'b1, 64'd1);
    drive_wb(0, 6'd50, 64'h5); #1;
    n_tests++; if (bus.issue_valid !== 1'b0) begin n_fail++; $display("FAIL flush_gate: got %0b expected 0", bus.issue_valid); end
    tick(); #1;
    n_tests++; if (bus.count !== 4'd0) begin n_fail++; $display("FAIL flush_count: got %0d expected 0", bus.count); end
    n_tests++; if (bus.issue_valid !== 1'b0) begin n_fail++; $display("FAIL flush_after: got %0b expected 0", bus.issue_valid); end
    n_tests++; if (bus.alloc_ready !== 1'b1) begin n_fail++; $display("FAIL flush_alloc_ready: got %0b expected 1", bus.alloc_ready); end
    bus.issue_ready = 1'b1;
    drive_wb(0, 6'd51, 64'h1); drive_wb(1, 6'd52, 64'h2); drive_wb(2, 6'd53, 64'h3);
    tick(); #1;
    n_tests++; if (bus.issue_valid !== 1'b0) begin n_fail++; $display("FAIL flush_stale1: got %0b expected 0", bus.issue_valid); end
    tick(); #1;
    n_tests++; if (bus.issue_valid !== 1'b0 || bus.count !== 4'd0) begin n_fail++; $display("FAIL flush_stale2: got valid %0b count %0d expected 0 0", bus.issue_valid, bus.count); end
    bus.issue_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    bus.issue_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_alloc(6'(20 + i), 7'b0110011, 12'd0, 6'd0, 1'b1, 64'(100 + i), 6'd0, 1'b1, 64'd0);
      #1;
      if (i > 0) begin
        n_tests++; if (bus.issue_valid !== 1'b1 || bus.issue_tag !== 6'(19 + i)) begin n_fail++; $display("FAIL b2b_tag%0d: got valid %0b tag %0d expected valid 1 tag %0d", i, bus.issue_valid, bus.issue_tag, 19 + i); end
        n_tests++; if (bus.issue_src1 !== 64'(99 + i)) begin n_fail++; $display("FAIL b2b_src1_%0d: got %0d expected %0d", i, bus.issue_src1, 99 + i); end
        n_tests++; if (bus.count !== 4'd1) begin n_fail++; $display("FAIL b2b_count%0d: got %0d expected 1", i, bus.count); end
      end
      tick();
    end
    #1;
    n_tests++; if (bus.issue_tag !== 6'd23) begin n_fail++; $display("FAIL b2b_last: got %0d expected 23", bus.issue_tag); end
    tick(); #1;
    n_tests++; if (bus.count !== 4'd0) begin n_fail++; $display("FAIL b2b_drain: got %0d expected 0", bus.count); end
    bus.issue_ready = 1'b0;
  endtask

  task automatic test_imm_mux();
`ifdef RS_IMM_MUX_EN
    bus.issue_ready = 1'b1;
    drive_alloc(6'd30, 7'b0010011, 12'hFFF, 6'd0, 1'b1, 64'd1, 6'd60, 1'b0, 64'h1234);
    tick(); #1;
    n_tests++; if (bus.issue_valid !== 1'b1) begin n_fail++; $display("FAIL imm_valid: got %0b expected 1", bus.issue_valid); end
    n_tests++; if (bus.issue_src2 !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_fail++; $display("FAIL imm_src2: got %0h expected ffffffffffffffff", bus.issue_src2); end
    n_tests++; if (bus.issue_imm !== 12'hFFF) begin n_fail++; $display("FAIL imm_field: got %0h expected fff", bus.issue_imm); end
    drive_alloc(6'd31, 7'b0000011, 12'h005, 6'd0, 1'b1, 64'd1, 6'd61, 1'b0, 64'h1234);
    tick(); #1;
    n_tests++; if (bus.issue_src2 !== 64'd5 || bus.issue_tag !== 6'd31) begin n_fail++; $display("FAIL imm_load: got src2 %0h tag %0d expected 5 31", bus.issue_src2, bus.issue_tag); end
    tick(); #1;
    n_tests++; if (bus.count !== 4'd0) begin n_fail++; $display("FAIL imm_count: got %0d expected 0", bus.count); end
`else
    bus.issue_ready = 1'b0;
    drive_alloc(6'd30, 7'b0010011, 12'hFFF, 6'd0, 1'b1, 64'd1, 6'd60, 1'b0, 64'h1234);
    tick(); #1;
    n_tests++; if (bus.issue_valid !== 1'b0) begin n_fail++; $display("FAIL noimm_wait: got %0b expected 0", bus.issue_valid); end
    drive_wb(1, 6'd60, 64'h1234);
    tick(); #1;
    n_tests++; if (bus.issue_src2 !== 64'h1234) begin n_fail++; $display("FAIL noimm_src2: got %0h expected 1234", bus.issue_src2); end
    n_tests++; if (bus.issue_imm !== 12'hFFF) begin n_fail++; $display("FAIL noimm_imm: got %0h expected fff", bus.issue_imm); end
    bus.issue_ready = 1'b1;
    tick(); #1;
    n_tests++; if (bus.count !== 4'd0) begin n_fail++; $display("FAIL noimm_count: got %0d expected 0", bus.count); end
`endif
    bus.issue_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    bus.issue_ready = 1'b0;
    drive_alloc(6'd7, 7'b0110011, 12'd0, 6'd0, 1'b1, 64'h77, 6'd0, 1'b1, 64'h78);
    tick(); #1;
    n_tests++; if (bus.issue_src1 !== 64'h77) begin n_fail++; $display("FAIL rmid_pre: got %0h expected 77", bus.issue_src1); end
    res_n = 1'b0;
    tick(); res_n = 1'b1; #1;
    n_tests++; if (bus.count !== 4'd0 || bus.issue_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_state: got count %0d valid %0b expected 0 0", bus.count, bus.issue_valid); end
    n_tests++; if (bus.issue_src1 !== 64'd0 || bus.issue_tag !== 6'd0) begin n_fail++; $display("FAIL rmid_payload: got src1 %0h tag %0d expected 0 0", bus.issue_src1, bus.issue_tag); end
    n_tests++; if (bus.alloc_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_alloc_ready: got %0b expected 1", bus.alloc_ready); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_alloc_bypass();
    test_wb_priority();
    test_age_hold();
    test_full();
    test_flush();
    test_back_to_back();
    test_imm_mux();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rs_param.md
Name: rs_param

Overview:
Parametrised reservation station, the successor to the fixed 4-entry RS. It holds up to DEPTH renamed instructions until both source operands are available. It wakes operands from NUM_WB result-broadcast buses, including at allocation time, and issues the oldest ready entry to one execution unit over a valid/ready handshake. It sits between rename/RF read and one execution unit (INT or LS), and supports pipeline flush.

Parameters:
DEPTH, 8, number of entries (power of two, 2..32)
NUM_WB, 4, number of result broadcast ports (commit + forwarding paths)
XLEN, 64, operand width
TAG_W, 6, physical/ROB tag width

Ports:
clk  in  1  clock
res_n  in  1  synchronous active-low reset
flush  in  1  discard all entries
alloc_valid  in  1  new instruction offered
alloc_ready  out  1  RS can accept (not full)
alloc_opcode  in  7  opcode
alloc_funct3  in  3  funct3
alloc_imm  in  12  immediate
alloc_tag  in  TAG_W  ROB tag
alloc_rd  in  TAG_W  destination tag
alloc_src1_tag / alloc_src2_tag  in  TAG_W  producer tags
alloc_src1_val / alloc_src2_val  in  XLEN  RF values
alloc_src1_rdy / alloc_src2_rdy  in  1  RF value already valid
wb_valid  in  NUM_WB  broadcast valid per port
wb_tag  in  NUM_WB*TAG_W  broadcast tags, port p at [p*TAG_W +: TAG_W]
wb_data  in  NUM_WB*XLEN  broadcast results
issue_valid  out  1  an entry is ready and presented
issue_ready  in  1  execution unit accepts
issue_opcode, issue_funct3, issue_imm, issue_tag, issue_rd  out  as alloc  payload of selected entry
issue_src1, issue_src2  out  XLEN  operand values
count  out  $clog2(DEPTH+1)  occupied entries

Behaviour:
- Reset (res_n=0 at posedge): all entries invalid, all operand-ready bits 0, age state cleared, count=0. Issue payload outputs reset to 0.
- Post-reset outputs: alloc_ready=1, issue_valid=0.
- alloc_ready = (count != DEPTH). It is purely a function of state, never of issue_ready; a slot freed by issue becomes allocatable the next cycle.
- Allocation fires on alloc_valid && alloc_ready at the posedge. The entry goes to the lowest-index free slot and becomes the youngest.
- Per source, the operand is taken from:
  - the RF value when src_rdy=1;
  - otherwise, a same-cycle wb port with wb_valid[p] && wb_tag[p]==src_tag (that data captured, rdy set);
  - otherwise, waiting.
- Wakeup: every cycle, each valid entry with a not-ready source compares its tag against all wb ports. On a match it captures the data and sets rdy at the posedge.
- Multiple wb ports matching one source: the lowest port index wins.
- Ready means both rdy bits are set.
- A source woken in cycle N makes the entry issueable from cycle N+1. Alloc in N with both sources ready makes it issueable at N+1.
- Selection: oldest ready entry by a DEPTH x DEPTH age matrix; ties are impossible.
- issue_valid and payload are combinational from registered entry state. Payload is held stable while issue_valid && !issue_ready.
- The selected entry is freed at the posedge where issue_valid && issue_ready.
- count: +1 on alloc, -1 on issue. Simultaneous alloc and issue leave it unchanged.
- flush=1: issue_valid forced 0 that cycle, alloc is ignored, and all entries are invalid after the posedge. Flush has priority over alloc, issue and wakeup.
- Reset mid-operation behaves like flush, and additionally clears payload registers.
- Full (count==DEPTH): alloc_valid is ignored and entry contents are untouched.
- Empty: issue_valid=0, and a stale payload is permitted.

Optional Feature:
RS_IMM_MUX_EN
- Defined: at allocation, if alloc_opcode is OP-IMM (0010011), LOAD (0000011) or JALR (1100111), source 2 is replaced by sign-extended alloc_imm to XLEN with rdy=1, and alloc_src2_* is ignored.
- Undefined: source 2 is always taken from alloc_src2_*, and issue_imm is the only immediate path.

Decomposition:
- rs_pkg holds: XLEN/TAG_W defaults, the rs_entry_t struct (valid, opcode, funct3, imm, tag, rd, src tag/val/rdy x2), and opcode constants.
- One sub-module, rs_age_matrix: tracks allocation order. Inputs are alloc one-hot, free one-hot, flush and the ready vector; output is the oldest-ready one-hot.

Test Plan:
- Reset, then alloc one entry with both srcs rdy, src1=5, src2=7, tag=3, issue_ready=1 -> issue_valid=1 next cycle with src1=5, src2=7, tag=3; count returns 0 after handshake.
- Alloc src1_tag=12 not rdy while wb port 2 broadcasts tag 12, data 0xAB in the same cycle -> entry captures 0xAB and issues next cycle.
- Alloc A (waiting on tag 9), then B (ready), then broadcast tag 9 -> B issues first. With issue_ready=0 for 3 cycles, B's payload is held; then A issues.
- Fill DEPTH=8 entries all waiting -> alloc_ready=0, count=8; a 9th alloc_valid is ignored. Broadcast wakes one; it issues; alloc_ready=1 the following cycle.
- Four waiting entries, assert flush in the same cycle as alloc_valid and a matching wb -> issue_valid=0, count=0 next cycle, no stale issue afterwards.
- With RS_IMM_MUX_EN, alloc OP-IMM imm=0xFFF with src2 not rdy -> issue_src2=0xFFFF_FFFF_FFFF_FFFF without any broadcast.
